id_ex_reg: RTL
==============

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of PC/operand/immediate fields.
REQ-002 Parameter: REG_ADDR_W, 5, register-index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hold current contents (load-use hazard).
REQ-006 flush  input  1  replace contents with a bubble (branch taken / hazard).
REQ-007 id_valid  input  1  ID stage holds a real instruction.
REQ-008 id_pc, id_rs1_data, id_rs2_data, id_imm  input  WIDTH each  decoded operands.
REQ-009 id_rs1, id_rs2, id_rd  input  REG_ADDR_W each  register indices.
REQ-010 id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_branch  input  1 each  control bits.
REQ-011 id_alu_op  input  2  ALU operation class; id_wb_sel  input  2  write-back source select (drives the EX/WB 4:1 select downstream).
REQ-012 ex_* outputs  output  same widths  registered copies of every id_* input, including ex_valid.
REQ-013 bubble_cnt  output  16  count of bubbles inserted since reset.

Function
REQ-014 Every ex_* output SHALL be driven directly from a register; no combinational input-to-output path.
REQ-015 Latency SHALL be exactly one clock: a field present at edge N appears on ex_* after edge N.
REQ-016 Priority at each edge SHALL be reset > flush > stall > load.
REQ-017 Load (no reset/flush/stall): all ex_* fields SHALL take the id_* values.
REQ-018 Stall: all ex_* fields, including ex_valid, SHALL hold; bubble_cnt SHALL hold.
REQ-019 Flush: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch SHALL become 0, ex_alu_op and ex_wb_sel SHALL become 2'b00, all data and index fields SHALL become 0.
REQ-020 Flush with stall asserted SHALL behave as flush (REQ-016).
REQ-021 Load with id_valid=0 SHALL clear control bits as in REQ-019 while capturing data fields, so an invalid slot never writes registers or memory.
REQ-022 bubble_cnt SHALL increment by 1 on each edge where flush=1 or (load with id_valid=0); it SHALL saturate at 16'hFFFF, not wrap.
REQ-023 ex_rd SHALL be forced to 0 whenever ex_reg_write is 0, so forwarding comparisons never match a non-writing slot.

Reset
REQ-024 On a rising edge with reset=1 every ex_* output and bubble_cnt SHALL become 0, regardless of stall/flush.
REQ-025 Reset asserted mid-stream SHALL discard the held instruction; the first edge after reset deasserts loads normally.
REQ-026 No asynchronous reset or initial-value dependence SHALL exist.

Structure
REQ-027 The bubble control encoding (zero control word, ALU_OP and WB_SEL encodings 00..11) SHALL live in the shared pipeline package used by decode and EX.
REQ-028 One sub-module, pipe_field, SHALL implement a WIDTH-parameterised register with synchronous reset, clear and enable; id_ex_reg instantiates it per field group.
REQ-029 The saturating counter SHALL be local to id_ex_reg.

Verification
REQ-030 Reset: drive all id_* to nonzero, reset=1 one edge -> all ex_* = 0, bubble_cnt = 0.
REQ-031 Load: id_pc=32'h0000_0040, id_rd=5'd7, id_reg_write=1, id_wb_sel=2'b10, id_valid=1 -> next cycle ex_pc=32'h40, ex_rd=7, ex_wb_sel=2'b10, ex_valid=1.
REQ-032 Stall: after REQ-031 load, stall=1 for 3 edges with id_pc=32'h44 -> ex_pc remains 32'h40 for 3 cycles, then 32'h44 after stall drops.
REQ-033 Flush+stall: stall=1, flush=1 one edge -> ex_valid=0, ex_reg_write=0, ex_rd=0, bubble_cnt increments by 1.
REQ-034 Invalid slot: id_valid=0, id_reg_write=1, id_rd=5'd3, id_mem_write=1 -> ex_reg_write=0, ex_mem_write=0, ex_rd=0, bubble_cnt+1.
REQ-035 Saturation: force 65 536 consecutive flushes -> bubble_cnt = 16'hFFFF and stays 16'hFFFF on further flushes.

Source files
------------

// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline definitions for the decode and execute stages:
// ALU/WB select encodings, the control word, and the bubble constant.
package id_ex_reg_pkg;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_SUB    = 2'b01,
    ALU_FUNCT  = 2'b10,
    ALU_BRANCH = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  typedef struct packed {
    logic    valid;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    branch;
    alu_op_e alu_op;
    wb_sel_e wb_sel;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // A bubble is an all-zero control word: no writes, no memory access.
  localparam ctrl_t CTRL_BUBBLE = '0;

  localparam logic [15:0] BUBBLE_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/id_ex_reg_pipe_field.sv
// Generic pipeline field register: synchronous reset > clear > enable.
module pipe_field #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Field storage; reset and clear both produce zero, enable loads d.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush-to-bubble and a saturating
// bubble counter. All ex_* outputs come straight from registers.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [WIDTH-1:0]      id_pc,
  input  logic [WIDTH-1:0]      id_rs1_data,
  input  logic [WIDTH-1:0]      id_rs2_data,
  input  logic [WIDTH-1:0]      id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic                  id_branch,
  input  logic [1:0]            id_alu_op,
  input  logic [1:0]            id_wb_sel,
  output logic                  ex_valid,
  output logic [WIDTH-1:0]      ex_pc,
  output logic [WIDTH-1:0]      ex_rs1_data,
  output logic [WIDTH-1:0]      ex_rs2_data,
  output logic [WIDTH-1:0]      ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic [1:0]            ex_alu_op,
  output logic [1:0]            ex_wb_sel,
  output logic [15:0]           bubble_cnt
);

  localparam int unsigned DATA_W = 4 * WIDTH + 2 * REG_ADDR_W;

  logic                  w_load_en;
  logic                  w_bubble;
  logic [DATA_W-1:0]     w_data_d;
  logic [DATA_W-1:0]     w_data_q;
  ctrl_t                 w_ctrl_d;
  logic [CTRL_W-1:0]     w_ctrl_q;
  ctrl_t                 w_ctrl_ex;
  logic [REG_ADDR_W-1:0] w_rd_d;
  logic [15:0]           r_bubble_cnt;

  assign w_load_en = ~stall;
  // A bubble is inserted by a flush (wins over stall) or by loading an invalid slot.
  assign w_bubble  = flush | (~stall & ~id_valid);

  assign w_data_d = {id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2};

  // Invalid slots load the bubble control word; data fields are still captured.
  always_comb begin
    w_ctrl_d = CTRL_BUBBLE;
    if (id_valid) begin
      w_ctrl_d.valid     = 1'b1;
      w_ctrl_d.reg_write = id_reg_write;
      w_ctrl_d.mem_read  = id_mem_read;
      w_ctrl_d.mem_write = id_mem_write;
      w_ctrl_d.alu_src   = id_alu_src;
      w_ctrl_d.branch    = id_branch;
      w_ctrl_d.alu_op    = alu_op_e'(id_alu_op);
      w_ctrl_d.wb_sel    = wb_sel_e'(id_wb_sel);
    end
  end

  // rd is masked on the way in, so the stored rd is zero exactly when the
  // stored reg_write is zero and the output stays a pure register.
  assign w_rd_d = (id_valid && id_reg_write) ? id_rd : '0;

  pipe_field #(.WIDTH(DATA_W)) u_data (
    .clk (clk),
    .rst (reset),
    .clr (flush),
    .en  (w_load_en),
    .d   (w_data_d),
    .q   (w_data_q)
  );

  pipe_field #(.WIDTH(CTRL_W)) u_ctrl (
    .clk (clk),
    .rst (reset),
    .clr (flush),
    .en  (w_load_en),
    .d   (w_ctrl_d),
    .q   (w_ctrl_q)
  );

  pipe_field #(.WIDTH(REG_ADDR_W)) u_rd (
    .clk (clk),
    .rst (reset),
    .clr (flush),
    .en  (w_load_en),
    .d   (w_rd_d),
    .q   (ex_rd)
  );

  assign {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2} = w_data_q;

  assign w_ctrl_ex    = ctrl_t'(w_ctrl_q);
  assign ex_valid     = w_ctrl_ex.valid;
  assign ex_reg_write = w_ctrl_ex.reg_write;
  assign ex_mem_read  = w_ctrl_ex.mem_read;
  assign ex_mem_write = w_ctrl_ex.mem_write;
  assign ex_alu_src   = w_ctrl_ex.alu_src;
  assign ex_branch    = w_ctrl_ex.branch;
  assign ex_alu_op    = w_ctrl_ex.alu_op;
  assign ex_wb_sel    = w_ctrl_ex.wb_sel;

  // Saturating count of inserted bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != BUBBLE_CNT_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;

endmodule
